// File: rtl/imem_fetch_ctrl.sv
// IF-stage sequencer: owns the PC, drives the instruction memory address and the IF/ID register.
// Optional macro FETCH_PERF_EN adds saturating fetch/stall performance counters.
module imem_fetch_ctrl #(
    parameter int unsigned IMEM_WORDS   = 128,
    parameter logic [5:0]  HALT_OPCODE  = 6'b111111,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
`ifdef FETCH_PERF_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic        halted
);

    localparam logic [1:0] StBoot   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StDrain  = 2'd2;
    localparam logic [1:0] StHalted = 2'd3;

    localparam int unsigned CntW      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CntW-1:0] DrainInit = CntW'(DRAIN_CYCLES - 1);
    localparam logic [31:0] MemBytes  = 32'(IMEM_WORDS * 4);

    logic [1:0]      state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     pc4_q, pc4_d;
    logic            halted_q, halted_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        halt_hit;
    logic        fetch_load;

    assign pc_plus4 = pc_q + 32'd4;
    assign target   = redirect_target & ~32'd3;
    // Past-the-end fetches are treated exactly like the sentinel word.
    assign halt_hit = (imem_instr[31:26] == HALT_OPCODE) || (pc_q >= MemBytes);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        halted_d   = halted_q;
        cnt_d      = cnt_q;
        fetch_load = 1'b0;
        unique case (state_q)
            StBoot: begin
                valid_d = 1'b0;
                instr_d = '0;
                pc_d    = redirect_valid ? target : 32'd0;
                state_d = StRun;
            end
            StRun: begin
                if (redirect_valid) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    instr_d = '0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (halt_hit) begin
                    valid_d = 1'b0;
                    instr_d = '0;
                    cnt_d   = DrainInit;
                    state_d = StDrain;
                end else begin
                    pc_d       = pc_plus4;
                    valid_d    = 1'b1;
                    instr_d    = imem_instr;
                    pc4_d      = pc_plus4;
                    fetch_load = 1'b1;
                end
            end
            StDrain: begin
                valid_d = 1'b0;
                instr_d = '0;
                if (redirect_valid) begin
                    // A late-resolving older branch cancels the pending halt.
                    pc_d    = target;
                    state_d = StRun;
                end else if (cnt_q == '0) begin
                    halted_d = 1'b1;
                    state_d  = StHalted;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StBoot;
            pc_q     <= 32'hFFFF_FFFC;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            pc4_q    <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            pc4_q    <= pc4_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fetch_load && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if ((state_q == StRun) && stall && !redirect_valid
            && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign if_id_valid    = valid_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_imem_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic        v;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        h;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        halted;

    logic [31:0] mem [0:127];
    exp_t        exp_q[$];
    string       name_q[$];
    int          n_cmp;
    int          n_bad;

    imem_fetch_ctrl #(
        .IMEM_WORDS  (128),
        .HALT_OPCODE (6'b111111),
        .DRAIN_CYCLES(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .pc             (pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .halted         (halted)
    );

    assign imem_instr = (imem_addr < 32'd512) ? mem[imem_addr[8:2]] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string nm, input exp_t e, input bit chk_p4);
        exp_t a;
        exp_t w;
        a.pc    = pc;
        a.v     = if_id_valid;
        a.instr = if_id_instr;
        a.p4    = chk_p4 ? if_id_pc_plus4 : 32'h0;
        a.h     = halted;
        w       = e;
        if (!chk_p4) w.p4 = 32'h0;
        n_cmp++;
        if ((a != w) || (imem_addr != e.pc)) begin
            n_bad++;
            $display("FAIL %s: got pc=%h addr=%h v=%b instr=%h p4=%h h=%b want pc=%h v=%b instr=%h p4=%h h=%b",
                     nm, a.pc, imem_addr, a.v, a.instr, a.p4, a.h,
                     w.pc, w.v, w.instr, w.p4, w.h);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check_out(n, e, e.v);
        end
    end

    // Drive one cycle's inputs; the expectation describes outputs after the next edge.
    task automatic cyc(input string nm, input logic st, input logic rv, input logic [31:0] tg,
                       input logic [31:0] epc, input logic ev, input logic [31:0] ei,
                       input logic [31:0] ep4, input logic eh);
        exp_t e;
        stall           = st;
        redirect_valid  = rv;
        redirect_target = tg;
        @(posedge clk);
        e.pc = epc; e.v = ev; e.instr = ei; e.p4 = ep4; e.h = eh;
        exp_q.push_back(e);
        name_q.push_back(nm);
        #1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
    endtask

    // Reset is asserted mid-cycle and checked before any clock edge can occur.
    task automatic reset_dut(input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        e.pc = 32'hFFFF_FFFC; e.v = 1'b0; e.instr = 32'h0; e.p4 = 32'h0; e.h = 1'b0;
        check_out(nm, e, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        clear_mem();

        // Short program ending in the sentinel; stall during drain must not delay halt.
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0003;
        mem[2] = 32'hFC00_0000;
        reset_dut("rst_init");
        cyc("t1_boot",   0, 0, 0, 32'h0, 0, 32'h0,         0,     0);
        cyc("t1_f0",     0, 0, 0, 32'h4, 1, 32'h2008_0005, 32'h4, 0);
        cyc("t1_f4",     0, 0, 0, 32'h8, 1, 32'h2009_0003, 32'h8, 0);
        cyc("t1_hdet",   0, 0, 0, 32'h8, 0, 32'h0,         0,     0);
        cyc("t1_drain1", 0, 0, 0, 32'h8, 0, 32'h0,         0,     0);
        cyc("t1_drain2", 1, 0, 0, 32'h8, 0, 32'h0,         0,     0);
        cyc("t1_drain3", 0, 0, 0, 32'h8, 0, 32'h0,         0,     0);
        cyc("t1_halt",   0, 0, 0, 32'h8, 0, 32'h0,         0,     1);
        cyc("t1_frozen", 1, 1, 32'h40, 32'h8, 0, 32'h0,    0,     1);
        reset_dut("rst_mid_halted");

        // Stall hold, then redirect beating stall with low target bits cleared.
        clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = 32'h1111_0000 + 32'(i);
        mem[8] = 32'h2222_0008;
        reset_dut("rst_t2");
        cyc("t2_boot",   0, 0, 0,      32'h0,  0, 32'h0,         0,      0);
        cyc("t2_f0",     0, 0, 0,      32'h4,  1, 32'h1111_0000, 32'h4,  0);
        cyc("t2_f4",     0, 0, 0,      32'h8,  1, 32'h1111_0001, 32'h8,  0);
        cyc("t2_stall1", 1, 0, 0,      32'h8,  1, 32'h1111_0001, 32'h8,  0);
        cyc("t2_stall2", 1, 0, 0,      32'h8,  1, 32'h1111_0001, 32'h8,  0);
        cyc("t2_f8",     0, 0, 0,      32'hC,  1, 32'h1111_0002, 32'hC,  0);
        cyc("t2_fC",     0, 0, 0,      32'h10, 1, 32'h1111_0003, 32'h10, 0);
        cyc("t2_redir",  1, 1, 32'h23, 32'h20, 0, 32'h0,         0,      0);
        cyc("t2_f20",    0, 0, 0,      32'h24, 1, 32'h2222_0008, 32'h24, 0);

        // Sentinel squashed by redirect; redirect during drain resumes fetching.
        clear_mem();
        mem[0]  = 32'h3000_0000;
        mem[1]  = 32'h3000_0001;
        mem[2]  = 32'h3000_0002;
        mem[3]  = 32'hFC00_0000;
        mem[16] = 32'h4000_0010;
        mem[17] = 32'hFC00_0000;
        mem[24] = 32'h6000_0018;
        mem[26] = 32'hFC00_0000;
        reset_dut("rst_t3");
        cyc("t3_boot",    0, 0, 0,      32'h0,  0, 32'h0,         0,      0);
        cyc("t3_f0",      0, 0, 0,      32'h4,  1, 32'h3000_0000, 32'h4,  0);
        cyc("t3_f4",      0, 0, 0,      32'h8,  1, 32'h3000_0001, 32'h8,  0);
        cyc("t3_f8",      0, 0, 0,      32'hC,  1, 32'h3000_0002, 32'hC,  0);
        cyc("t3_sent_rd", 0, 1, 32'h40, 32'h40, 0, 32'h0,         0,      0);
        cyc("t3_f40",     0, 0, 0,      32'h44, 1, 32'h4000_0010, 32'h44, 0);
        cyc("t3_hdet",    0, 0, 0,      32'h44, 0, 32'h0,         0,      0);
        cyc("t3_drain",   1, 0, 0,      32'h44, 0, 32'h0,         0,      0);
        cyc("t3_drn_rd",  0, 1, 32'h61, 32'h60, 0, 32'h0,         0,      0);
        cyc("t3_f60",     0, 0, 0,      32'h64, 1, 32'h6000_0018, 32'h64, 0);
        cyc("t3_f64",     0, 0, 0,      32'h68, 1, 32'h0,         32'h68, 0);
        cyc("t3_hdet2",   0, 0, 0,      32'h68, 0, 32'h0,         0,      0);
        cyc("t3_drain2",  0, 0, 0,      32'h68, 0, 32'h0,         0,      0);
        reset_dut("rst_mid_drain");

        // Straight-line code running off the end of memory halts at 0x200.
        clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = 32'h0100_0000 + 32'(i);
        reset_dut("rst_t4");
        cyc("t4_boot", 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 128; i++) begin
            cyc("t4_seq", 0, 0, 0, 32'((i + 1) * 4), 1, 32'h0100_0000 + 32'(i),
                32'((i + 1) * 4), 0);
        end
        cyc("t4_hdet",   0, 0, 0, 32'h200, 0, 32'h0, 0, 0);
        cyc("t4_drain1", 0, 0, 0, 32'h200, 0, 32'h0, 0, 0);
        cyc("t4_drain2", 0, 0, 0, 32'h200, 0, 32'h0, 0, 0);
        cyc("t4_drain3", 0, 0, 0, 32'h200, 0, 32'h0, 0, 0);
        cyc("t4_halt",   0, 0, 0, 32'h200, 0, 32'h0, 0, 1);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_queue: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
